// File: rtl/load_store_unit.sv
// Load/store unit: turns an M-stage memory access into a single data-memory
// bus transaction, stalls the pipeline while it is outstanding, extends load
// data, and aborts with a bus error if the memory does not respond in time.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        BusyM,
   output logic        MisalignM,
   output logic        BusErrM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Counter value on the last cycle allowed in REQ+WAIT before aborting.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] rdata_q, rdata_d;
   logic        buserr_q, buserr_d;

   logic        access_bad;
   logic [3:0]  new_be;
   logic [31:0] new_wdata;

   // Pick the addressed lane out of the bus word and extend it to 32 bits.
   function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [31:0] sh;
      sh = raw >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   // Classify the incoming access and pre-compute its byte enables and lane data.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      access_bad = 1'b0;
      new_be     = 4'b1111;
      new_wdata  = WriteDataM;
      case (Funct3M[1:0])
         2'b00: begin
            new_be    = 4'b0001 << ALUResultM[1:0];
            new_wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            access_bad = ALUResultM[0];
            new_be     = 4'b0011 << ALUResultM[1:0];
            new_wdata  = {2{WriteDataM[15:0]}};
         end
         2'b10:   access_bad = |ALUResultM[1:0];
         default: access_bad = 1'b1;
      endcase
      if (MemWriteM && Funct3M[2]) access_bad = 1'b1;
      if (!MemWriteM && (Funct3M == 3'b110)) access_bad = 1'b1;
   end

   // Next-state logic: accept, request, wait for data, or time out.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      off_d    = off_q;
      f3_d     = f3_q;
      rdata_d  = rdata_q;
      buserr_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (MemReqM && !access_bad) begin
               state_d = REQ;
               cnt_d   = '0;
               we_d    = MemWriteM;
               addr_d  = {ALUResultM[31:2], 2'b00};
               be_d    = new_be;
               wdata_d = new_wdata;
               off_d   = ALUResultM[1:0];
               f3_d    = Funct3M;
            end
         end
         REQ: begin
            if (dmem_gnt && we_q) begin
               state_d = DONE;
            end else if (dmem_gnt && dmem_rvalid) begin
               rdata_d = extend_load(dmem_rdata, off_q, f3_q);
               state_d = DONE;
            end else if (cnt_q == LAST_CNT) begin
               state_d  = DONE;
               buserr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (dmem_gnt) state_d = WAIT;
            end
         end
         WAIT: begin
            if (dmem_rvalid) begin
               rdata_d = extend_load(dmem_rdata, off_q, f3_q);
               state_d = DONE;
            end else if (cnt_q == LAST_CNT) begin
               state_d  = DONE;
               buserr_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      req_d = (state_d == REQ);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         off_q    <= '0;
         f3_q     <= '0;
         rdata_q  <= '0;
         buserr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         off_q    <= off_d;
         f3_q     <= f3_d;
         rdata_q  <= rdata_d;
         buserr_q <= buserr_d;
      end
   end

   // Stall and misalign flags respond in the accepting cycle; reset silences them.
   assign BusyM     = reset & (((state_q == IDLE) & MemReqM & ~access_bad) |
                               (state_q == REQ) | (state_q == WAIT));
   assign MisalignM = reset & (state_q == IDLE) & MemReqM & access_bad;
   assign BusErrM   = buserr_q;
   assign ReadDataM = rdata_q;

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the cycles spent in REQ+WAIT before a bus-error abort (legal range 2..255).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-low reset.
REQ-004 MemReqM  in  1  SHALL mean a load/store is present in the M stage.
REQ-005 MemWriteM  in  1  SHALL select store (1) or load (0).
REQ-006 Funct3M  in  3  SHALL encode size/sign per RV32I (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-007 ALUResultM  in  32  SHALL be the effective byte address produced by the execute-stage ALU.
REQ-008 WriteDataM  in  32  SHALL be the store data, right-aligned.
REQ-009 ReadDataM  out  32  SHALL be the extended load result.
REQ-010 BusyM  out  1  SHALL request a pipeline stall.
REQ-011 MisalignM  out  1  SHALL flag a misaligned access or illegal Funct3M.
REQ-012 BusErrM  out  1  SHALL flag a timed-out access.
REQ-013 dmem_req, dmem_we  out  1 each; dmem_addr  out  32; dmem_be  out  4; dmem_wdata  out  32  SHALL form the data-memory request.
REQ-014 dmem_gnt  in  1; dmem_rvalid  in  1; dmem_rdata  in  32  SHALL form the data-memory response.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-016 Misalign SHALL be: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; illegal Funct3M = loads 011/110/111, stores other than 000/001/010.
REQ-017 IDLE, MemReqM=1, no misalign: latch access, go REQ; BusyM=1 same cycle (combinational).
REQ-018 IDLE, MemReqM=1, misaligned: MisalignM=1 combinationally, BusyM=0, no bus request, stay IDLE.
REQ-019 REQ: dmem_req=1 (registered) with stable dmem_we/addr/be/wdata until dmem_gnt sampled high.
REQ-020 dmem_addr SHALL be {addr[31:2],2'b00}; dmem_be SB=0001<<addr[1:0], SH=0011<<addr[1:0], SW=1111 (same for loads).
REQ-021 dmem_wdata SHALL replicate byte (x4) for SB, halfword (x2) for SH, word for SW.
REQ-022 REQ + gnt, store: go DONE. Load: go WAIT; if dmem_rvalid also high that cycle, capture data and go DONE directly.
REQ-023 WAIT + dmem_rvalid: capture dmem_rdata >> (8*addr[1:0]), sign-extend (LB/LH) or zero-extend (LBU/LHU), go DONE.
REQ-024 Timeout counter SHALL clear on entering REQ and increment each cycle in REQ/WAIT; at TIMEOUT_CYCLES without completion, go DONE with BusErrM=1, ReadDataM unchanged, dmem_req dropped.
REQ-025 DONE: BusyM=0 for exactly one cycle, then unconditionally IDLE; BusErrM high only in DONE.
REQ-026 ReadDataM SHALL be registered, update only on load completion, hold otherwise.
REQ-027 dmem_rvalid outside REQ/WAIT SHALL be ignored.
REQ-028 Minimum latency: store BusyM high 2 cycles; load 2 cycles (gnt+rvalid together) or 3 (rvalid one cycle after gnt).

Reset
REQ-029 reset low at any clock edge SHALL force IDLE, counter 0, all outputs 0 including ReadDataM, dmem_req, BusyM, MisalignM, BusErrM.
REQ-030 Reset mid-REQ/WAIT SHALL abandon the access; a later dmem_rvalid SHALL not alter ReadDataM.

Verification
REQ-031 LB addr 0x1003, gnt c1, rvalid c2 rdata 0x80FF1234 -> dmem_be 1000, ReadDataM 0xFFFFFF80 in DONE c3; LBU -> 0x00000080.
REQ-032 SH addr 0x2002, WriteDataM 0x0000ABCD, gnt c1 -> dmem_addr 0x2000, be 1100, wdata 0xABCDABCD, we=1; DONE c2.
REQ-033 LW addr 0x3001 -> MisalignM=1, BusyM=0, dmem_req never asserted; same for Funct3M=011 load.
REQ-034 TIMEOUT_CYCLES=4, LW 0x4000, gnt never -> BusyM high 5 cycles, DONE with BusErrM=1, ReadDataM unchanged.
REQ-035 LW in WAIT, reset low one cycle, rvalid 0xDEADBEEF next cycle -> IDLE, ReadDataM 0, BusyM 0.
REQ-036 Back-to-back SW then LW, gnt delayed 3 cycles each -> dmem_req held stable while waiting, exactly one DONE per access.
